alu_arbiter: RTL

Round-robin arbiter that shares the single combinational 32-bit ALU between two requesters (r0 = main execute path, r1 = address/branch-compare unit). Each requester issues a complete ALU command through a valid/ready handshake. The arbiter registers the winning command, drives the ALU for one cycle, captures the result and zero flag, and returns them to the winner through a response valid/ready handshake. It sits between the pipeline control logic and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for the ALU arbiter: command handshake plus response handshake.
// Latency: none, wires only.
// Backpressure: req_ready/resp_ready carry flow control in both directions.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             twoc;
  logic [2:0]       setflag;
  logic             lr;
  logic             arith;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  // Requester side: issues commands, consumes responses.
  modport master (
    output req_valid, in1, in2, op, twoc, setflag, lr, arith, resp_ready,
    input  req_ready, resp_valid, result, zero
  );

  // Arbiter side: accepts commands, produces responses.
  modport slave (
    input  req_valid, in1, in2, op, twoc, setflag, lr, arith, resp_ready,
    output req_ready, resp_valid, result, zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Latency: accept in N, ALU evaluated in N+1, response valid in N+2; one command per 3 cycles max.
// Backpressure: req_ready only in IDLE; RESP holds result until the winner's resp_ready.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     r0,
  alu_arbiter_if.slave     r1,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_op,
  output logic             alu_twoc,
  output logic [2:0]       alu_setflag,
  output logic             alu_lr,
  output logic             alu_arith,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       op;
    logic             twoc;
    logic [2:0]       setflag;
    logic             lr;
    logic             arith;
  } cmd_t;

  state_t           state;
  state_t           nextState;
  logic             prio;
  logic             winner;
  logic             accept;
  logic             grantedRespReady;
  cmd_t             cmdReg;
  cmd_t             req0Cmd;
  cmd_t             req1Cmd;
  logic [WIDTH-1:0] resultReg;
  logic             zeroReg;

  assign req0Cmd = {r0.in1, r0.in2, r0.op, r0.twoc, r0.setflag, r0.lr, r0.arith};
  assign req1Cmd = {r1.in1, r1.in2, r1.op, r1.twoc, r1.setflag, r1.lr, r1.arith};

  assign grantedRespReady = grant_id ? r1.resp_ready : r0.resp_ready;

  // Pick a winner in IDLE (prio breaks ties) and sequence IDLE -> EXEC -> RESP.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    winner    = prio;
    case (state)
      IDLE: begin
        if (r0.req_valid && r1.req_valid) begin
          winner = prio;
          accept = 1'b1;
        end else if (r0.req_valid) begin
          winner = 1'b0;
          accept = 1'b1;
        end else if (r1.req_valid) begin
          winner = 1'b1;
          accept = 1'b1;
        end
        if (accept) begin
          nextState = EXEC;
        end
      end
      EXEC: nextState = RESP;
      RESP: begin
        if (grantedRespReady) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Command/result registers, grant tracking and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdReg    <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b0;
      grant_id  <= 1'b0;
      prio      <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        cmdReg   <= winner ? req1Cmd : req0Cmd;
        grant_id <= winner;
      end
      if (state == EXEC) begin
        resultReg <= alu_result;
        zeroReg   <= alu_zero;
      end
      if (state == RESP && grantedRespReady) begin
        prio <= ~grant_id;
      end
    end
  end

  // ALU is always fed from the command register so requester inputs never glitch it.
  assign alu_in1     = cmdReg.in1;
  assign alu_in2     = cmdReg.in2;
  assign alu_op      = cmdReg.op;
  assign alu_twoc    = cmdReg.twoc;
  assign alu_setflag = cmdReg.setflag;
  assign alu_lr      = cmdReg.lr;
  assign alu_arith   = cmdReg.arith;

  assign r0.req_ready  = accept && !winner;
  assign r1.req_ready  = accept && winner;
  assign r0.resp_valid = (state == RESP) && !grant_id;
  assign r1.resp_valid = (state == RESP) && grant_id;
  assign r0.result     = resultReg;
  assign r1.result     = resultReg;
  assign r0.zero       = zeroReg;
  assign r1.zero       = zeroReg;

  assign busy = (state != IDLE);

endmodule
